// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, state encoding and default width for the calculator
package calc_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [1:0] ADD      = 2'b00;
  localparam logic [1:0] MULTIPLY = 2'b01;
  localparam logic [1:0] SUBTRACT = 2'b10;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    OP_WAIT = 2'b01,
    ENTER_B = 2'b10,
    RESULT  = 2'b11
  } state_t;

endpackage

// File: rtl/calc_if.sv
// rtl/calc_if.sv - keypad strobes in, display/status out
interface calc_if #(
  parameter int WIDTH = 16
);

  logic             newhex;
  logic [3:0]       hexcode;
  logic             newop;
  logic [1:0]       opcode;
  logic             eq;
  logic [WIDTH-1:0] display;
  logic             ovf;
  logic             result_valid;
  logic [1:0]       mode;

  modport master (
    output newhex, hexcode, newop, opcode, eq,
    input  display, ovf, result_valid, mode
  );

  modport slave (
    input  newhex, hexcode, newop, opcode, eq,
    output display, ovf, result_valid, mode
  );

endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/sub/mul with carry, borrow or high-half overflow
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      MULTIPLY: begin
        result = prod[WIDTH-1:0];
        ovf    = |prod[2*WIDTH-1:WIDTH];
      end
      SUBTRACT: begin
        // diff[WIDTH] is the borrow out: set exactly when b > a
        result = diff[WIDTH-1:0];
        ovf    = diff[WIDTH];
      end
      default: begin
        result = sum[WIDTH-1:0];
        ovf    = sum[WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - operand entry, pending operator and evaluation sequencing
module calc_controller
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic  clock,
  input  logic  reset,
  calc_if.slave bus
);

  localparam int             MAXDIG = WIDTH / 4;
  localparam int             CW     = $clog2(MAXDIG + 1);
  localparam logic [CW-1:0]  MAXCNT = CW'(MAXDIG);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, entry, entry_n, display_r, display_n;
  logic [1:0]       op_reg, op_n;
  logic [CW-1:0]    dig_cnt, cnt_n;
  logic             ovf_r, ovf_n, rv_r, rv_n;

  logic [WIDTH-1:0] alu_res, shifted, first_digit;
  logic             alu_ovf, do_eq, do_op, do_hex, digit_ok;

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (acc),
    .b      (entry),
    .op     (op_reg),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // eq arrives together with newop; eq must win, and hex only counts when alone
  assign do_eq       = bus.eq;
  assign do_op       = bus.newop & ~bus.eq;
  assign do_hex      = bus.newhex & ~bus.newop & ~bus.eq;
  assign digit_ok    = dig_cnt < MAXCNT;
  assign shifted     = {entry[WIDTH-5:0], bus.hexcode};
  assign first_digit = WIDTH'(bus.hexcode);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ENTER_A;
      acc       <= '0;
      entry     <= '0;
      op_reg    <= '0;
      dig_cnt   <= '0;
      display_r <= '0;
      ovf_r     <= 1'b0;
      rv_r      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      entry     <= entry_n;
      op_reg    <= op_n;
      dig_cnt   <= cnt_n;
      display_r <= display_n;
      ovf_r     <= ovf_n;
      rv_r      <= rv_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    entry_n   = entry;
    op_n      = op_reg;
    cnt_n     = dig_cnt;
    display_n = display_r;
    ovf_n     = ovf_r;
    rv_n      = 1'b0;
    case (state)
      ENTER_A: begin
        if (do_eq) begin
          acc_n     = entry;
          display_n = entry;
          ovf_n     = 1'b0;
          rv_n      = 1'b1;
          state_n   = RESULT;
        end else if (do_op) begin
          acc_n     = entry;
          display_n = entry;
          op_n      = bus.opcode;
          entry_n   = '0;
          cnt_n     = '0;
          state_n   = OP_WAIT;
        end else if (do_hex && digit_ok) begin
          entry_n   = shifted;
          cnt_n     = dig_cnt + CW'(1);
          display_n = shifted;
        end
      end
      OP_WAIT: begin
        if (do_eq) begin
          display_n = acc;
          rv_n      = 1'b1;
          state_n   = RESULT;
        end else if (do_op) begin
          op_n = bus.opcode;
        end else if (do_hex) begin
          entry_n   = first_digit;
          cnt_n     = CW'(1);
          display_n = first_digit;
          state_n   = ENTER_B;
        end
      end
      ENTER_B: begin
        if (do_eq || do_op) begin
          acc_n     = alu_res;
          ovf_n     = ovf_r | alu_ovf;
          display_n = alu_res;
          rv_n      = 1'b1;
          if (do_eq) begin
            state_n = RESULT;
          end else begin
            op_n    = bus.opcode;
            entry_n = '0;
            cnt_n   = '0;
            state_n = OP_WAIT;
          end
        end else if (do_hex && digit_ok) begin
          entry_n   = shifted;
          cnt_n     = dig_cnt + CW'(1);
          display_n = shifted;
        end
      end
      RESULT: begin
        if (do_op) begin
          op_n    = bus.opcode;
          entry_n = '0;
          cnt_n   = '0;
          state_n = OP_WAIT;
        end else if (do_hex) begin
          entry_n   = first_digit;
          cnt_n     = CW'(1);
          ovf_n     = 1'b0;
          display_n = first_digit;
          state_n   = ENTER_A;
        end
      end
      default: state_n = ENTER_A;
    endcase
  end

  assign bus.display      = display_r;
  assign bus.ovf          = ovf_r;
  assign bus.result_valid = rv_r;
  assign bus.mode         = state;

endmodule

// File: tb/tb_calc_controller.sv
// tb/tb_calc_controller.sv - directed plan plus random keypresses against an arithmetic model
module tb_calc_controller;

  localparam int    W = 16;
  localparam longint M = 65536;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  calc_if #(.WIDTH(W)) bus ();

  calc_controller #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase 0 first operand, 1 operator pending, 2 second operand, 3 showing result
  int     m_phase;
  longint m_acc, m_entry, m_disp;
  int     m_op, m_digits;
  bit     m_ovf, m_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " display"}, 32'(bus.display), 32'(m_disp));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(m_ovf));
    check({tag, " result_valid"}, 32'(bus.result_valid), 32'(m_rv));
    check({tag, " mode"}, 32'(bus.mode), 32'(m_phase));
  endtask

  task automatic model_reset();
    m_phase = 0; m_acc = 0; m_entry = 0; m_disp = 0;
    m_op = 0; m_digits = 0; m_ovf = 0; m_rv = 0;
  endtask

  task automatic evaluate();
    longint r;
    bit     o;
    if (m_op == 1) begin
      r = m_acc * m_entry;
      o = (r >= M);
      r = r % M;
    end else if (m_op == 2) begin
      o = (m_entry > m_acc);
      r = (m_acc - m_entry + M) % M;
    end else begin
      r = m_acc + m_entry;
      o = (r >= M);
      r = r % M;
    end
    m_acc  = r;
    m_disp = r;
    m_ovf  = m_ovf | o;
    m_rv   = 1;
  endtask

  task automatic model_hex(input int d);
    if (m_phase == 0 || m_phase == 2) begin
      if (m_digits < W / 4) begin
        m_entry = (m_entry * 16 + d) % M;
        m_digits++;
        m_disp = m_entry;
      end
    end else begin
      if (m_phase == 3) m_ovf = 0;
      m_entry  = d;
      m_digits = 1;
      m_disp   = d;
      m_phase  = (m_phase == 1) ? 2 : 0;
    end
  endtask

  task automatic model_op(input int o);
    if (m_phase == 0) begin
      m_acc  = m_entry;
      m_disp = m_acc;
    end else if (m_phase == 2) begin
      evaluate();
    end
    m_op = o;
    if (m_phase != 1) begin
      m_entry  = 0;
      m_digits = 0;
    end
    m_phase = 1;
  endtask

  task automatic model_eq();
    if (m_phase == 0) begin
      m_acc  = m_entry;
      m_disp = m_acc;
      m_ovf  = 0;
      m_rv   = 1;
      m_phase = 3;
    end else if (m_phase == 1) begin
      m_disp = m_acc;
      m_rv   = 1;
      m_phase = 3;
    end else if (m_phase == 2) begin
      evaluate();
      m_phase = 3;
    end
  endtask

  // drive one cycle of strobes, advance the model by priority, then compare
  task automatic apply(input bit nh, input int hc, input bit no, input int oc, input bit e,
                       input string tag);
    bus.newhex  = nh;
    bus.hexcode = 4'(hc);
    bus.newop   = no;
    bus.opcode  = 2'(oc);
    bus.eq      = e;
    @(negedge clock);
    bus.newhex = 1'b0;
    bus.newop  = 1'b0;
    bus.eq     = 1'b0;
    m_rv = 0;
    if (e) model_eq();
    else if (no) model_op(oc);
    else if (nh) model_hex(hc);
    check_model(tag);
  endtask

  task automatic hex(input int d);  apply(1, d, 0, 0, 0, "hex");  endtask
  task automatic op(input int o);   apply(0, 0, 1, o, 0, "op");   endtask
  task automatic equals();          apply(0, 0, 1, 0, 1, "eq");   endtask
  task automatic idle();            apply(0, 0, 0, 0, 0, "idle"); endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  initial begin
    bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.opcode = 0; bus.eq = 0;
    model_reset();
    @(negedge clock);

    do_reset();
    check("tp reset display", 32'(bus.display), 32'h0);
    hex(1); hex(2);
    check("tp 12", 32'(bus.display), 32'h0012);
    op(0); hex(3); hex(4); equals();
    check("tp 46", 32'(bus.display), 32'h0046);
    check("tp 46 rv", 32'(bus.result_valid), 32'h1);
    idle();
    check("tp rv one cycle", 32'(bus.result_valid), 32'h0);

    do_reset();
    hex(10); hex(11); hex(12); hex(13);
    check("tp abcd", 32'(bus.display), 32'hABCD);
    hex(14);
    check("tp fifth digit", 32'(bus.display), 32'hABCD);

    do_reset();
    hex(3); op(2); hex(5); equals();
    check("tp sub", 32'(bus.display), 32'hFFFE);
    check("tp sub ovf", 32'(bus.ovf), 32'h1);
    hex(7);
    check("tp new digit", 32'(bus.display), 32'h0007);
    check("tp new digit ovf", 32'(bus.ovf), 32'h0);
    check("tp new digit mode", 32'(bus.mode), 32'h0);

    do_reset();
    hex(2); op(1); hex(3); op(0);
    check("tp chain 6", 32'(bus.display), 32'h0006);
    check("tp chain 6 rv", 32'(bus.result_valid), 32'h1);
    hex(4); equals();
    check("tp chain a", 32'(bus.display), 32'h000A);
    check("tp chain a rv", 32'(bus.result_valid), 32'h1);

    do_reset();
    hex(1); hex(0); hex(0); op(1); hex(1); hex(0); hex(0); equals();
    check("tp mul ovf disp", 32'(bus.display), 32'h0);
    check("tp mul ovf", 32'(bus.ovf), 32'h1);
    op(0); hex(1);
    apply(0, 0, 1, 0, 1, "eq+op");
    check("tp eq wins mode", 32'(bus.mode), 32'h3);
    check("tp sticky ovf", 32'(bus.ovf), 32'h1);
    check("tp eq wins disp", 32'(bus.display), 32'h0001);

    do_reset();
    hex(5); op(0); hex(9);
    do_reset();
    check("tp midreset mode", 32'(bus.mode), 32'h0);
    check("tp midreset disp", 32'(bus.display), 32'h0);
    hex(7);
    check("tp after reset", 32'(bus.display), 32'h0007);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k < 9)       hex($urandom_range(0, 15));
      else if (k < 13) op($urandom_range(0, 3));
      else if (k < 15) equals();
      else if (k < 17) idle();
      else if (k < 19) apply(1, $urandom_range(0, 15), 1, $urandom_range(0, 3), 0, "hex+op");
      else             do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
